systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - job sequencer feeding weights and skewed activations into the systolic MAC array
module systolic_seq_ctrl #(
    parameter int ARR_SIZE      = 4,
    parameter int VERTICAL_BW   = 32,
    parameter int HORIZONTAL_BW = 16,
    parameter int LEN_W         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LEN_W-1:0]                  cfg_len,
    output logic                              busy,
    output logic                              done,
    input  logic                              w_valid,
    output logic                              w_ready,
    input  logic [VERTICAL_BW*ARR_SIZE-1:0]   w_data,
    input  logic                              a_valid,
    output logic                              a_ready,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] a_data,
    output logic                              mac_i_mode,
    output logic [VERTICAL_BW*ARR_SIZE-1:0]   mac_vertical_input,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] mac_horizontal_input,
    output logic                              acc_clr
);

    localparam int VW        = VERTICAL_BW * ARR_SIZE;
    localparam int HW        = HORIZONTAL_BW * ARR_SIZE;
    localparam int DRAIN_CYC = 2 * ARR_SIZE - 1;
    localparam int DW        = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              w_ready_q, w_ready_d;
    logic              a_ready_q, a_ready_d;
    logic              i_mode_q, i_mode_d;
    logic              acc_clr_q, acc_clr_d;
    logic [VW-1:0]     vert_q, vert_d;
    logic [HW-1:0]     skew_in;

    logic w_hs;
    logic a_hs;

    // Ready flags are registered copies of the state, so a handshake implies the matching state.
    assign w_hs = w_valid & w_ready_q;
    assign a_hs = a_valid & a_ready_q;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        drain_cnt_d = drain_cnt_q;
        acc_clr_d   = 1'b0;
        i_mode_d    = 1'b0;
        vert_d      = '0;
        skew_in     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len != '0) begin
                        len_d      = cfg_len;
                        beat_cnt_d = '0;
                        acc_clr_d  = 1'b1;
                        state_d    = S_LOAD_W;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_hs) begin
                    i_mode_d = 1'b1;
                    vert_d   = w_data;
                    if (beat_cnt_q == LEN_W'(ARR_SIZE - 1)) begin
                        beat_cnt_d = '0;
                        state_d    = S_COMPUTE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (a_hs) begin
                    skew_in = a_data;
                    // Compare against len-1 so the full 2^LEN_W-1 range needs no wider counter.
                    if (beat_cnt_q == len_q - LEN_W'(1)) begin
                        drain_cnt_d = '0;
                        state_d     = S_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DW'(DRAIN_CYC - 1)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        w_ready_d = (state_d == S_LOAD_W);
        a_ready_d = (state_d == S_COMPUTE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            w_ready_q   <= 1'b0;
            a_ready_q   <= 1'b0;
            i_mode_q    <= 1'b0;
            acc_clr_q   <= 1'b0;
            vert_q      <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            w_ready_q   <= w_ready_d;
            a_ready_q   <= a_ready_d;
            i_mode_q    <= i_mode_d;
            acc_clr_q   <= acc_clr_d;
            vert_q      <= vert_d;
        end
    end

    // Row i sees its slice i cycles after row 0, giving the diagonal wavefront the array expects.
    for (genvar i = 0; i < ARR_SIZE; i++) begin : g_row
        logic [HORIZONTAL_BW-1:0] row_q;

        if (i == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (rst) begin
                    row_q <= '0;
                end else begin
                    row_q <= skew_in[0 +: HORIZONTAL_BW];
                end
            end
        end else begin : g_delay
            logic [HORIZONTAL_BW-1:0] dly_q [0:i-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < i; k++) begin
                        dly_q[k] <= '0;
                    end
                    row_q <= '0;
                end else begin
                    dly_q[0] <= skew_in[i*HORIZONTAL_BW +: HORIZONTAL_BW];
                    for (int k = 1; k < i; k++) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                    row_q <= dly_q[i-1];
                end
            end
        end

        assign mac_horizontal_input[i*HORIZONTAL_BW +: HORIZONTAL_BW] = row_q;
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign w_ready            = w_ready_q;
    assign a_ready            = a_ready_q;
    assign mac_i_mode         = i_mode_q;
    assign mac_vertical_input = vert_q;
    assign acc_clr            = acc_clr_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - scoreboard bench for systolic_seq_ctrl with a cycle-timeline job model
module tb_systolic_seq_ctrl;

    localparam int N  = 4;
    localparam int VB = 32;
    localparam int HB = 16;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [LW-1:0]   cfg_len;
    logic            busy;
    logic            done;
    logic            w_valid;
    logic            w_ready;
    logic [N*VB-1:0] w_data;
    logic            a_valid;
    logic            a_ready;
    logic [N*HB-1:0] a_data;
    logic            mac_i_mode;
    logic [N*VB-1:0] mac_vertical_input;
    logic [N*HB-1:0] mac_horizontal_input;
    logic            acc_clr;

    systolic_seq_ctrl #(
        .ARR_SIZE(N), .VERTICAL_BW(VB), .HORIZONTAL_BW(HB), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .mac_i_mode(mac_i_mode), .mac_vertical_input(mac_vertical_input),
        .mac_horizontal_input(mac_horizontal_input), .acc_clr(acc_clr)
    );

    always #5 clk = ~clk;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct packed {
        int              c;
        logic [N*VB-1:0] d;
    } vev_t;

    vev_t          vq[$];
    int            dq[$];
    logic [HB-1:0] exp_h[int];
    bit            exp_busy[int];
    bit            exp_wr[int];
    bit            exp_ar[int];
    bit            exp_clr[int];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    vev_t          mev;
    logic [HB-1:0] meh;
    int            mkey;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("busy",    128'(busy),    128'(exp_busy.exists(cyc)));
            chk("w_ready", 128'(w_ready), 128'(exp_wr.exists(cyc)));
            chk("a_ready", 128'(a_ready), 128'(exp_ar.exists(cyc)));
            chk("acc_clr", 128'(acc_clr), 128'(exp_clr.exists(cyc)));
            if (vq.size() > 0 && vq[0].c == cyc) begin
                mev = vq.pop_front();
                chk("i_mode", 128'(mac_i_mode), 128'(1));
                chk("vertical", 128'(mac_vertical_input), 128'(mev.d));
            end else begin
                chk("i_mode", 128'(mac_i_mode), 128'(0));
                chk("vertical", 128'(mac_vertical_input), 128'(0));
            end
            for (int i = 0; i < N; i++) begin
                mkey = cyc * N + i;
                if (exp_h.exists(mkey)) begin
                    meh = exp_h[mkey];
                    exp_h.delete(mkey);
                end else begin
                    meh = '0;
                end
                chk($sformatf("row%0d", i), 128'(mac_horizontal_input[i*HB +: HB]), 128'(meh));
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
                void'(dq.pop_front());
                chk("done", 128'(done), 128'(1));
            end else begin
                chk("done", 128'(done), 128'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        w_valid = 1'($urandom);
        a_valid = 1'($urandom);
        w_data  = {$urandom, $urandom, $urandom, $urandom};
        a_data  = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            junk();
            step();
        end
    endtask

    // mode 0: valid always high, mode 1: 1-0-1-0, mode 2: random with 2/3 duty
    function automatic bit pat(input int mode, input int idx);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (idx % 2) == 0;
        return $urandom_range(0, 2) != 0;
    endfunction

    task automatic flush(input int r);
        while (vq.size() > 0 && vq[vq.size()-1].c > r) void'(vq.pop_back());
        for (int c = r + 1; c <= r + N; c++) begin
            for (int i = 0; i < N; i++) begin
                if (exp_h.exists(c * N + i)) exp_h.delete(c * N + i);
            end
        end
    endtask

    // Timeline model: start at c0, weights from c0+1 until N accepted, then len vectors,
    // then 2N-1 drain cycles and one DONE cycle.
    task automatic run_job(input int len, input int mode, input int kill_at,
                           input int mid_len, input bit five_first);
        int   nw;
        int   na;
        int   idx;
        vev_t ev;
        junk();
        start   = 1'b1;
        cfg_len = LW'(len);
        step();
        start = 1'b0;
        if (len == 0) begin
            exp_busy[cyc] = 1'b1;
            dq.push_back(cyc);
            junk();
            step();
            return;
        end
        exp_clr[cyc] = 1'b1;
        nw  = 0;
        idx = 0;
        while (nw < N) begin
            exp_busy[cyc] = 1'b1;
            exp_wr[cyc]   = 1'b1;
            junk();
            start = (mid_len > 0) && (idx == 2);
            if (mid_len > 0) cfg_len = LW'(mid_len);
            w_valid = pat(mode, idx);
            idx++;
            if (w_valid) begin
                ev.c = cyc + 1;
                ev.d = w_data;
                vq.push_back(ev);
                nw++;
            end
            step();
        end
        start = 1'b0;
        na  = 0;
        idx = 0;
        while (na < len) begin
            exp_busy[cyc] = 1'b1;
            exp_ar[cyc]   = 1'b1;
            junk();
            if (kill_at >= 0 && na == kill_at) begin
                a_valid = 1'b0;
                rst     = 1'b1;
                step();
                rst = 1'b0;
                flush(cyc - 1);
                return;
            end
            a_valid = pat(mode, idx);
            idx++;
            if (a_valid) begin
                if (five_first && na == 0) a_data = {N{16'h0005}};
                for (int i = 0; i < N; i++) begin
                    exp_h[(cyc + 1 + i) * N + i] = a_data[i*HB +: HB];
                end
                na++;
            end
            step();
        end
        repeat (2 * N - 1) begin
            exp_busy[cyc] = 1'b1;
            junk();
            step();
        end
        exp_busy[cyc] = 1'b1;
        dq.push_back(cyc);
        junk();
        step();
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        cfg_len = '0;
        w_valid = 1'b0;
        a_valid = 1'b0;
        w_data  = '0;
        a_data  = '0;
        step();
        step();
        rst = 1'b0;

        run_job(8, 0, -1, 0, 1'b0);
        run_job(3, 0, -1, 0, 1'b1);
        run_job(3, 1, -1, 0, 1'b0);
        idle(2);
        run_job(0, 0, -1, 0, 1'b0);
        run_job(5, 2, -1, 2, 1'b0);
        run_job(6, 0, 3, 0, 1'b0);
        run_job(2, 0, -1, 0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(1, 12), 2, -1, 0, 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(N + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
